reaction_ctrl_multi: RTL and testbench

//  Parametrised multi-round reaction-timer controller; successor to the single-round game FSM.

---
 rtl/reaction_ctrl_multi_if.sv | 31 +++
 rtl/reaction_ctrl_multi.sv | 196 +++++++++++++++++++
 tb/tb_reaction_ctrl_multi.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/reaction_ctrl_multi_if.sv
// Signal bundle between input conditioning, the reaction controller and the display mux.
// The controller takes the slave view; the stimulus side takes the master view.
interface reaction_ctrl_multi_if #(
  parameter int N_SW   = 10,
  parameter int TIME_W = 20,
  parameter int RAND_W = 15
);
  logic              tick;
  logic              start;
  logic [N_SW-1:0]   switch;
  logic [RAND_W-1:0] rand_delay;
  logic [3:0]        rand_idx;
  logic [N_SW-1:0]   led;
  logic [2:0]        state_o;
  logic [3:0]        round_o;
  logic [TIME_W-1:0] last_time;
  logic [TIME_W-1:0] avg_time;
  logic [TIME_W-1:0] best_time;
  logic              penalty;
  logic              game_done;

  modport slave (
    input  tick, start, switch, rand_delay, rand_idx,
    output led, state_o, round_o, last_time, avg_time, best_time, penalty, game_done
  );

  modport master (
    output tick, start, switch, rand_delay, rand_idx,
    input  led, state_o, round_o, last_time, avg_time, best_time, penalty, game_done
  );
endinterface

// File: rtl/reaction_ctrl_multi.sv
// Multi-round reaction-timer controller: random delay, one-hot target LED, ms timing,
// false-start / wrong-switch / timeout penalties, per-game average and best time.
module reaction_ctrl_multi #(
  parameter int N_SW     = 10,
  parameter int N_ROUNDS = 4,
  parameter int TIME_W   = 20,
  parameter int MAX_TIME = 9999,
  parameter int RAND_W   = 15
) (
  input logic clk,
  input logic rst,
  reaction_ctrl_multi_if.slave bus
);
  localparam int SUM_W = TIME_W + 4;
  localparam int RND_SH = $clog2(N_ROUNDS);
  localparam int CMP_W = (RAND_W > TIME_W) ? RAND_W : TIME_W;
  localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);
  localparam logic [3:0] LAST_RND = 4'(N_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_DELAY  = 3'd2,
    S_REACT  = 3'd3,
    S_RESULT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              start_q;
  logic [TIME_W-1:0] tmr_q, tmr_d;
  logic [TIME_W-1:0] delay_q, delay_d;
  logic [3:0]        target_q, target_d;
  logic [TIME_W-1:0] rtime_q, rtime_d;
  logic [N_SW-1:0]   led_q, led_d;
  logic [3:0]        round_q, round_d;
  logic [TIME_W-1:0] last_q, last_d;
  logic [TIME_W-1:0] avg_q, avg_d;
  logic [TIME_W-1:0] best_q, best_d;
  logic              pen_q, pen_d;
  logic              done_q, done_d;
  logic [SUM_W-1:0]  sum_q, sum_d;

  logic              start_pulse_s;
  logic [N_SW-1:0]   oh_s;
  logic              tgt_on_s;
  logic              other_on_s;
  logic [CMP_W-1:0]  rd_ext_s;
  logic [SUM_W-1:0]  sum_next_s;

  assign start_pulse_s = bus.start & ~start_q;
  assign oh_s          = N_SW'(1) << target_q;
  assign tgt_on_s      = |(bus.switch & oh_s);
  assign other_on_s    = |(bus.switch & ~oh_s);
  assign rd_ext_s      = CMP_W'(bus.rand_delay);
  assign sum_next_s    = sum_q + SUM_W'(rtime_q);

  // Next-state and datapath decode for the round sequencer.
  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    target_d = target_q;
    rtime_d  = rtime_q;
    led_d    = led_q;
    round_d  = round_q;
    last_d   = last_q;
    avg_d    = avg_q;
    best_d   = best_q;
    pen_d    = pen_q;
    sum_d    = sum_q;
    tmr_d    = (bus.tick && (tmr_q != MAX_T)) ? tmr_q + TIME_W'(1) : tmr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_pulse_s) begin
          state_d = S_ARM;
          round_d = 4'd0;
          sum_d   = '0;
          pen_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_ARM: begin
        if (bus.switch == '0) begin
          // Delays beyond the saturating timer range are clamped so DELAY always terminates.
          if (rd_ext_s == '0) begin
            delay_d = TIME_W'(1);
          end else if (rd_ext_s > CMP_W'(MAX_TIME)) begin
            delay_d = MAX_T;
          end else begin
            delay_d = TIME_W'(rd_ext_s);
          end
          target_d = ({1'b0, bus.rand_idx} < 5'(N_SW)) ? bus.rand_idx : 4'd0;
          tmr_d    = '0;
          state_d  = S_DELAY;
        end else begin
          state_d = S_ARM;
        end
      end
      S_DELAY: begin
        if (|bus.switch) begin
          rtime_d = MAX_T;
          pen_d   = 1'b1;
          state_d = S_RESULT;
        end else if (tmr_q == delay_q) begin
          tmr_d   = '0;
          led_d   = oh_s;
          state_d = S_REACT;
        end else begin
          state_d = S_DELAY;
        end
      end
      S_REACT: begin
        if (tgt_on_s && !other_on_s) begin
          rtime_d = tmr_q;
          pen_d   = 1'b0;
          state_d = S_RESULT;
        end else if (other_on_s || (tmr_q == MAX_T)) begin
          rtime_d = MAX_T;
          pen_d   = 1'b1;
          state_d = S_RESULT;
        end else begin
          state_d = S_REACT;
        end
      end
      S_RESULT: begin
        led_d  = '0;
        last_d = rtime_q;
        sum_d  = sum_next_s;
        if (!pen_q && (rtime_q < best_q)) begin
          best_d = rtime_q;
        end else begin
          best_d = best_q;
        end
        if (round_q == LAST_RND) begin
          avg_d   = TIME_W'(sum_next_s >> RND_SH);
          state_d = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = S_ARM;
        end
      end
      default: begin
        led_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      tmr_q    <= '0;
      delay_q  <= '0;
      target_q <= 4'd0;
      rtime_q  <= '0;
      led_q    <= '0;
      round_q  <= 4'd0;
      last_q   <= '0;
      avg_q    <= '0;
      best_q   <= {TIME_W{1'b1}};
      pen_q    <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= bus.start;
      tmr_q    <= tmr_d;
      delay_q  <= delay_d;
      target_q <= target_d;
      rtime_q  <= rtime_d;
      led_q    <= led_d;
      round_q  <= round_d;
      last_q   <= last_d;
      avg_q    <= avg_d;
      best_q   <= best_d;
      pen_q    <= pen_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
    end
  end

  assign bus.led       = led_q;
  assign bus.state_o   = state_q;
  assign bus.round_o   = round_q;
  assign bus.last_time = last_q;
  assign bus.avg_time  = avg_q;
  assign bus.best_time = best_q;
  assign bus.penalty   = pen_q;
  assign bus.game_done = done_q;
endmodule

// File: tb/tb_reaction_ctrl_multi.sv
// Directed bench for reaction_ctrl_multi: one task per scenario, tick held high so
// every clock is one timebase tick and reaction times are cycle-exact.
module tb_reaction_ctrl_multi;
  localparam int N_SW = 10, N_ROUNDS = 4, TIME_W = 20, MAX_TIME = 9999, RAND_W = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reaction_ctrl_multi_if #(.N_SW(N_SW), .TIME_W(TIME_W), .RAND_W(RAND_W)) bus ();

  reaction_ctrl_multi #(
    .N_SW(N_SW), .N_ROUNDS(N_ROUNDS), .TIME_W(TIME_W), .MAX_TIME(MAX_TIME), .RAND_W(RAND_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  logic [TIME_W-1:0] all_ones = '1;

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while ((bus.state_o !== s) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.state_o !== s) begin
      fails++;
      $display("FAIL %s: state_o=%0d required %0d (wait expired)", name, bus.state_o, s);
    end
  endtask

  task automatic wait_led(input int budget, input string name);
    int n = 0;
    while ((bus.led == '0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.led == '0) begin
      fails++;
      $display("FAIL %s: led never lit (wait expired)", name);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  // Wait for the LED, react t ticks later on channel ch, return at negedge after last_time updates.
  task automatic react(input int t, input int ch, input logic [3:0] idx);
    bus.rand_idx = idx;
    wait_led(2000, "react_led");
    repeat (t) @(posedge clk);
    #1 bus.switch = N_SW'(1) << ch;
    repeat (2) @(posedge clk);
    #1 bus.switch = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (bus.state_o !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
    tests++; if (bus.led !== '0) begin fails++; $display("FAIL reset_led: got %h want 0", bus.led); end
    tests++; if (bus.best_time !== all_ones) begin fails++; $display("FAIL reset_best: got %h want %h", bus.best_time, all_ones); end
    tests++; if ({bus.round_o, bus.last_time, bus.avg_time, bus.penalty, bus.game_done} !== '0) begin
      fails++; $display("FAIL reset_misc: round=%0d last=%0d avg=%0d pen=%b done=%b want all 0",
                        bus.round_o, bus.last_time, bus.avg_time, bus.penalty, bus.game_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_round();
    bus.rand_delay = 15'd5;
    bus.rand_idx   = 4'd3;
    pulse_start();
    react(42, 3, 4'd3);
    tests++; if (bus.last_time !== 20'd42) begin fails++; $display("FAIL r0_last: got %0d want 42", bus.last_time); end
    tests++; if (bus.best_time !== 20'd42) begin fails++; $display("FAIL r0_best: got %0d want 42", bus.best_time); end
    tests++; if (bus.penalty !== 1'b0) begin fails++; $display("FAIL r0_pen: got %b want 0", bus.penalty); end
    tests++; if (bus.round_o !== 4'd1) begin fails++; $display("FAIL r0_round: got %0d want 1", bus.round_o); end
  endtask

  task automatic test_false_start();
    bus.rand_delay = 15'd200;
    wait_state(3'd2, 100, "fs_delay");
    bus.switch = 10'b00_0000_0010;
    @(negedge clk);
    wait_state(3'd1, 10, "fs_arm");
    tests++; if (bus.last_time !== 20'd9999) begin fails++; $display("FAIL fs_last: got %0d want 9999", bus.last_time); end
    tests++; if (bus.penalty !== 1'b1) begin fails++; $display("FAIL fs_pen: got %b want 1", bus.penalty); end
    tests++; if (bus.best_time !== 20'd42) begin fails++; $display("FAIL fs_best: got %0d want 42", bus.best_time); end
    tests++; if (bus.round_o !== 4'd2) begin fails++; $display("FAIL fs_round: got %0d want 2", bus.round_o); end
    bus.rand_delay = 15'd5;
    bus.switch = '0;
  endtask

  task automatic test_finish_game1();
    react(100, 7, 4'd7);
    react(120, 2, 4'd2);
    // 42 + 9999 + 100 + 120 = 10261, /4 floor = 2565
    tests++; if (bus.game_done !== 1'b1) begin fails++; $display("FAIL g1_done: got %b want 1", bus.game_done); end
    tests++; if (bus.avg_time !== 20'd2565) begin fails++; $display("FAIL g1_avg: got %0d want 2565", bus.avg_time); end
    tests++; if (bus.state_o !== 3'd5) begin fails++; $display("FAIL g1_state: got %0d want 5", bus.state_o); end
    tests++; if (bus.best_time !== 20'd42) begin fails++; $display("FAIL g1_best: got %0d want 42", bus.best_time); end
  endtask

  task automatic test_average_game();
    bus.rand_idx = 4'd3;
    pulse_start();
    tests++; if ((bus.state_o !== 3'd1) || (bus.round_o !== 4'd0)) begin
      fails++; $display("FAIL g2_restart: state=%0d round=%0d want 1/0", bus.state_o, bus.round_o);
    end
    react(40, 3, 4'd3);
    react(60, 0, 4'd0);
    react(80, 9, 4'd9);
    react(101, 4, 4'd4);
    tests++; if (bus.game_done !== 1'b1) begin fails++; $display("FAIL g2_done: got %b want 1", bus.game_done); end
    tests++; if (bus.avg_time !== 20'd70) begin fails++; $display("FAIL g2_avg: got %0d want 70", bus.avg_time); end
    tests++; if (bus.best_time !== 20'd40) begin fails++; $display("FAIL g2_best: got %0d want 40", bus.best_time); end
    tests++; if (bus.last_time !== 20'd101) begin fails++; $display("FAIL g2_last: got %0d want 101", bus.last_time); end
  endtask

  task automatic test_arm_hold_and_timeout();
    bus.rand_idx   = 4'd12;
    bus.rand_delay = 15'd300;
    bus.switch     = 10'b00_0000_0100;
    pulse_start();
    repeat (10) @(negedge clk);
    tests++; if (bus.state_o !== 3'd1) begin fails++; $display("FAIL arm_hold: state=%0d want 1", bus.state_o); end
    bus.switch = '0;
    wait_state(3'd2, 10, "arm_release");
    pulse_start();
    tests++; if ((bus.state_o !== 3'd2) || (bus.round_o !== 4'd0)) begin
      fails++; $display("FAIL start_ignored: state=%0d round=%0d want 2/0", bus.state_o, bus.round_o);
    end
    wait_led(1000, "to_led");
    tests++; if (bus.led !== 10'b00_0000_0001) begin fails++; $display("FAIL idx_clamp_led: got %b want 0000000001", bus.led); end
    bus.rand_idx   = 4'd5;
    bus.rand_delay = 15'd5;
    wait_state(3'd4, 11000, "timeout_result");
    @(negedge clk);
    tests++; if (bus.penalty !== 1'b1) begin fails++; $display("FAIL to_pen: got %b want 1", bus.penalty); end
    tests++; if (bus.last_time !== 20'd9999) begin fails++; $display("FAIL to_last: got %0d want 9999", bus.last_time); end
    tests++; if (bus.best_time !== 20'd40) begin fails++; $display("FAIL to_best: got %0d want 40", bus.best_time); end
    tests++; if (bus.round_o !== 4'd1) begin fails++; $display("FAIL to_round: got %0d want 1", bus.round_o); end
  endtask

  task automatic test_reset_in_react();
    wait_led(1000, "rr_led");
    tests++; if (bus.led !== 10'b00_0010_0000) begin fails++; $display("FAIL rr_led5: got %b want 0000100000", bus.led); end
    rst = 1'b1;
    #1;
    tests++; if (bus.led !== '0) begin fails++; $display("FAIL rr_led: got %b want 0", bus.led); end
    tests++; if (bus.state_o !== 3'd0) begin fails++; $display("FAIL rr_state: got %0d want 0", bus.state_o); end
    tests++; if (bus.best_time !== all_ones) begin fails++; $display("FAIL rr_best: got %h want %h", bus.best_time, all_ones); end
    tests++; if ((bus.round_o !== 4'd0) || (bus.last_time !== '0) || (bus.game_done !== 1'b0)) begin
      fails++; $display("FAIL rr_misc: round=%0d last=%0d done=%b want 0", bus.round_o, bus.last_time, bus.game_done);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    bus.tick       = 1'b1;
    bus.start      = 1'b0;
    bus.switch     = '0;
    bus.rand_delay = 15'd5;
    bus.rand_idx   = 4'd0;
    test_reset();
    test_first_round();
    test_false_start();
    test_finish_game1();
    test_average_game();
    test_arm_hold_and_timeout();
    test_reset_in_react();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
